mips_inst_feeder: RTL



---
 rtl/mips_pkg.sv | 28 ++
 rtl/mips_inst_fifo.sv | 73 +++++++
 rtl/mips_inst_feeder.sv | 96 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction feeder and the execution block it drives.
// Opcode/funct constants are kept here so benches of both blocks agree on encodings.
package mips_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } asm_state_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/mips_inst_fifo.sv
// Synchronous word FIFO between the byte assembler and the issue register.
// A push while full is taken only when a pop frees the head slot in the same cycle.
module mips_inst_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [INST_W-1:0]          wdata,
  output logic [INST_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop) && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mips_inst_feeder.sv
// Byte-serial instruction assembler feeding a word FIFO and a registered issue port.
// Bytes arrive MSB first; the 4th byte of a word is held off only when it has nowhere to go.
module mips_inst_feeder
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       byte_valid,
  input  logic [BYTE_W-1:0]          byte_data,
  output logic                       byte_ready,
  input  logic                       flush,
  input  logic                       issue_en,
  output logic                       inst_valid,
  output logic [INST_W-1:0]          inst_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       partial
);

  asm_state_e        state_q, state_d;
  logic [23:0]       shreg_q, shreg_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [INST_W-1:0] fifo_rdata;
  logic [INST_W-1:0] push_word;

  mips_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (push_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    pop        = issue_en && !fifo_empty && !flush;
    byte_ready = !flush && !((state_q == B3) && fifo_full && !pop);
    accept     = byte_valid && byte_ready;
    push       = accept && (state_q == B3);
    push_word  = {shreg_q, byte_data};
    state_d    = state_q;
    shreg_d    = shreg_q;
    if (flush) begin
      state_d = B0;
      shreg_d = '0;
    end else if (accept) begin
      shreg_d = {shreg_q[15:0], byte_data};
      case (state_q)
        B0: state_d = B1;
        B1: state_d = B2;
        B2: state_d = B3;
        B3: state_d = B0;
        default: state_d = B0;
      endcase
    end
  end

  // Issue register: a pop presents the head for exactly one cycle, otherwise zeros.
  always_comb begin
    inst_valid_d = pop;
    inst_out_d   = pop ? fifo_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= B0;
      shreg_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign partial    = (state_q != B0);

endmodule
